// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Round-robin two-master arbiter in front of a fixed-latency
//               memory port; one access in flight, one-cycle ack to winner.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [1:0]    m0_size,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [1:0]    m1_size,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,
    output logic          mem_rd,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [1:0]    mem_size,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_error,
    output logic          owner,
    output logic          busy
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ISSUE    = 2'd1;
    localparam logic [1:0] c_WAIT     = 2'd2;
    localparam logic [1:0] c_ACK      = 2'd3;
    localparam logic [3:0] c_CNT_LOAD = 4'(MEM_LATENCY - 1);

    generate
        if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
            $error("mem_bus_arbiter: MEM_LATENCY must be in 1..15");
        end
    endgenerate

    logic [1:0]    r_state;
    logic          r_last;
    logic          r_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [1:0]    r_size;
    logic [3:0]    r_cnt;

    logic          w_req_any;
    logic          w_grant;
    logic          w_ack;

    // Under contention the master that did not win last time gets the bus.
    assign w_req_any = m0_req | m1_req;
    assign w_grant   = (m0_req & m1_req) ? ~r_last : m1_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req_any) begin
                        r_owner <= w_grant;
                        r_last  <= w_grant;
                        r_we    <= w_grant ? m1_we    : m0_we;
                        r_addr  <= w_grant ? m1_addr  : m0_addr;
                        r_wdata <= w_grant ? m1_wdata : m0_wdata;
                        r_size  <= w_grant ? m1_size  : m0_size;
                        r_state <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_cnt   <= c_CNT_LOAD;
                    r_state <= (MEM_LATENCY > 1) ? c_WAIT : c_ACK;
                end
                c_WAIT: begin
                    // Leaving on the cycle whose decrement reaches zero keeps
                    // the ack exactly MEM_LATENCY cycles after the issue cycle.
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= c_ACK;
                    end
                end
                c_ACK: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != c_IDLE);
    assign owner     = r_owner;
    assign mem_rd    = (r_state == c_ISSUE) & ~r_we;
    assign mem_we    = (r_state == c_ISSUE) & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_size  = r_size;

    assign w_ack     = (r_state == c_ACK);
    assign m0_ack    = w_ack & ~r_owner;
    assign m1_ack    = w_ack & r_owner;
    assign m0_rdata  = m0_ack ? mem_rdata : '0;
    assign m1_rdata  = m1_ack ? mem_rdata : '0;
    assign m0_err    = m0_ack & mem_error;
    assign m1_err    = m1_ack & mem_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Scoreboard bench: random two-master traffic against a timeline
//               model (latency 3) plus directed latency-1 transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int LAT = 3;

    typedef struct {
        int          cyc;
        logic        m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  size;
        logic        err;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    // ---------------- main DUT (latency 3) ----------------
    logic [1:0]  req, we;
    logic [31:0] addr [2];
    logic [31:0] wdata[2];
    logic [1:0]  size [2];
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_rd, mem_we, mem_error, owner, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;
    wire  [1:0]  ack = {m1_ack, m0_ack};

    mem_bus_arbiter #(.MEM_LATENCY(LAT), .AW(32), .DW(32)) u_dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_size(size[0]),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_size(size[1]),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_error(mem_error),
        .owner(owner), .busy(busy)
    );

    // ---------------- second DUT (latency 1), directed ----------------
    logic        s0_req, s0_we, s1_req, s1_we;
    logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
    logic [1:0]  s0_size, s1_size;
    logic        s0_ack, s1_ack, s0_err, s1_err;
    logic [31:0] s0_rdata, s1_rdata;
    logic        smem_rd, smem_we, sowner, sbusy;
    logic [31:0] smem_addr, smem_wdata;
    logic [1:0]  smem_size;
    wire  [31:0] smem_rdata = (smem_addr == 32'h100) ? 32'hDEADBEEF : 32'h0;
    wire         smem_error = 1'b0;

    mem_bus_arbiter #(.MEM_LATENCY(1), .AW(32), .DW(32)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .m0_req(s0_req), .m0_we(s0_we), .m0_addr(s0_addr), .m0_wdata(s0_wdata), .m0_size(s0_size),
        .m0_ack(s0_ack), .m0_rdata(s0_rdata), .m0_err(s0_err),
        .m1_req(s1_req), .m1_we(s1_we), .m1_addr(s1_addr), .m1_wdata(s1_wdata), .m1_size(s1_size),
        .m1_ack(s1_ack), .m1_rdata(s1_rdata), .m1_err(s1_err),
        .mem_rd(smem_rd), .mem_we(smem_we), .mem_addr(smem_addr), .mem_wdata(smem_wdata),
        .mem_size(smem_size), .mem_rdata(smem_rdata), .mem_error(smem_error),
        .owner(sowner), .busy(sbusy)
    );

    // ---------------- memory device behind the main DUT ----------------
    function automatic logic [31:0] init_val(input logic [3:0] i);
        return 32'hC0DE0000 | (32'(i) * 32'h0101);
    endfunction

    function automatic logic err_of(input logic [31:0] a);
        return (a[5:2] == 4'd5) || (a[5:2] == 4'd11);
    endfunction

    logic [31:0] dev_mem[16];
    logic [15:0] dev_vld = '0;
    assign mem_rdata = dev_vld[mem_addr[5:2]] ? dev_mem[mem_addr[5:2]] : init_val(mem_addr[5:2]);
    assign mem_error = err_of(mem_addr);

    always @(negedge clk) begin
        if (mem_we) begin
            dev_mem[mem_addr[5:2]] <= mem_wdata;
            dev_vld[mem_addr[5:2]] <= 1'b1;
        end
    end

    // ---------------- reference model: bus timeline ----------------
    int          cyc = 0;
    int          free_cyc = 0;
    logic        last_g = 1'b1;
    logic [31:0] ref_mem[16];
    logic [15:0] ref_vld = '0;
    txn_t        ackq0[$], ackq1[$], mq[$];

    always @(posedge clk) begin
        txn_t        t;
        logic        w;
        logic [3:0]  idx;
        if (!rst) begin
            ackq0.delete(); ackq1.delete(); mq.delete();
            free_cyc = 0;
            last_g   = 1'b1;
        end else if (cyc >= free_cyc && req != 2'b00) begin
            w       = (req == 2'b11) ? ~last_g : req[1];
            last_g  = w;
            t.m     = w;
            t.we    = we[w];
            t.addr  = addr[w];
            t.wdata = wdata[w];
            t.size  = size[w];
            t.err   = err_of(t.addr);
            idx     = t.addr[5:2];
            if (t.we) begin
                ref_mem[idx] = t.wdata;
                ref_vld[idx] = 1'b1;
                t.rdata      = '0;
            end else begin
                t.rdata = ref_vld[idx] ? ref_mem[idx] : init_val(idx);
            end
            t.cyc = cyc + 1 + LAT;
            if (w) ackq1.push_back(t); else ackq0.push_back(t);
            t.cyc = cyc + 1;
            mq.push_back(t);
            free_cyc = cyc + LAT + 2;
        end
        cyc++;
    end

    // ---------------- monitor ----------------
    logic grant_log[$];
    int   ack_seen = 0;

    task automatic check_ack(input int m, input logic a, input logic [31:0] rd, input logic er);
        txn_t e;
        checks++;
        if (a) begin
            ack_seen++;
            if ((m == 0 && ackq0.size() == 0) || (m == 1 && ackq1.size() == 0)) begin
                errors++;
                $display("FAIL ack_unexpected m%0d: got ack at cyc %0d, want none", m, cyc);
            end else begin
                if (m == 0) e = ackq0.pop_front(); else e = ackq1.pop_front();
                grant_log.push_back(m[0]);
                if (cyc != e.cyc || er !== e.err || (!e.we && rd !== e.rdata)) begin
                    errors++;
                    $display("FAIL ack_m%0d: got cyc=%0d err=%b rdata=%h, want cyc=%0d err=%b rdata=%h (we=%b)",
                             m, cyc, er, rd, e.cyc, e.err, e.rdata, e.we);
                end
            end
        end else if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs_m%0d: got rdata=%h err=%b, want 0 0", m, rd, er);
        end
    endtask

    always @(negedge clk) begin
        txn_t e;
        if (rst) begin
            if (mem_rd || mem_we) begin
                checks++;
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected: got strobe at cyc %0d, want none", cyc);
                end else begin
                    e = mq.pop_front();
                    if (cyc != e.cyc || mem_we !== e.we || mem_rd !== ~e.we || mem_addr !== e.addr ||
                        mem_size !== e.size || owner !== e.m || busy !== 1'b1 ||
                        (e.we && mem_wdata !== e.wdata)) begin
                        errors++;
                        $display("FAIL issue: got cyc=%0d rd=%b we=%b addr=%h size=%0d owner=%b wdata=%h, want cyc=%0d we=%b addr=%h size=%0d owner=%b wdata=%h",
                                 cyc, mem_rd, mem_we, mem_addr, mem_size, owner, mem_wdata,
                                 e.cyc, e.we, e.addr, e.size, e.m, e.wdata);
                    end
                end
            end
            check_ack(0, m0_ack, m0_rdata, m0_err);
            check_ack(1, m1_ack, m1_rdata, m1_err);
            checks++;
            if (m0_ack && m1_ack) begin
                errors++;
                $display("FAIL dual_ack: got both acks, want at most one");
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic master(input int m, input int n, input bit back2back);
        int t;
        for (int i = 0; i < n; i++) begin
            if (!back2back) repeat ($urandom_range(0, 3)) @(negedge clk);
            req[m]   = 1'b1;
            we[m]    = 1'($urandom_range(0, 1));
            addr[m]  = 32'h100 + 32'($urandom_range(0, 15)) * 32'd4;
            wdata[m] = $urandom;
            size[m]  = 2'($urandom_range(0, 3));
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!ack[m] && t < 60);
            if (!ack[m]) begin
                errors++;
                $display("FAIL timeout_m%0d: got no ack in 60 cycles, want ack", m);
            end
            if (!back2back) req[m] = 1'b0;
        end
        req[m] = 1'b0;
    endtask

    task automatic chk_main_zero(input string name);
        chk(name, {m0_ack, m1_ack, m0_err, m1_err, mem_rd, mem_we, owner, busy,
                   |m0_rdata, |m1_rdata, |mem_addr, |mem_wdata, |mem_size}, 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, snap, t;
        logic alt;
        rst = 1'b0;
        req = '0; we = '0;
        for (int i = 0; i < 2; i++) begin addr[i] = '0; wdata[i] = '0; size[i] = '0; end
        s0_req = 0; s0_we = 0; s0_addr = '0; s0_wdata = '0; s0_size = '0;
        s1_req = 0; s1_we = 0; s1_addr = '0; s1_wdata = '0; s1_size = '0;
        repeat (3) @(negedge clk);
        chk_main_zero("reset_outputs");
        chk("reset_outputs_l1", {s0_ack, s1_ack, smem_rd, smem_we, sowner, sbusy, |smem_addr}, 64'h0);
        #2 rst = 1'b1;
        @(negedge clk);

        // latency 1: single read by m0
        s0_req = 1; s0_we = 0; s0_addr = 32'h100; s0_size = 2'd2;
        @(negedge clk);
        chk("l1_rd_strobe", {smem_rd, smem_we, sbusy, s0_ack}, 4'b1010);
        chk("l1_rd_addr", smem_addr, 32'h100);
        @(negedge clk);
        chk("l1_rd_ack", {s0_ack, s1_ack, smem_rd}, 3'b100);
        chk("l1_rd_data", s0_rdata, 32'hDEADBEEF);
        s0_req = 0;
        @(negedge clk);
        chk("l1_idle", {sbusy, s0_ack, |s0_rdata}, 3'b000);
        // latency 1: write by m1
        s1_req = 1; s1_we = 1; s1_addr = 32'h200; s1_wdata = 32'h12345678; s1_size = 2'd2;
        @(negedge clk);
        chk("l1_wr_strobe", {smem_rd, smem_we, sowner}, 3'b011);
        chk("l1_wr_fields", {smem_addr, smem_wdata}, {32'h200, 32'h12345678});
        chk("l1_wr_size", smem_size, 2'd2);
        @(negedge clk);
        chk("l1_wr_ack", {s1_ack, s1_err, s0_ack}, 3'b100);
        s1_req = 0;
        @(negedge clk);
        // latency 1: contention, m0 favoured since m1 won last
        s0_req = 1; s0_we = 0; s0_addr = 32'h100;
        s1_req = 1; s1_we = 0; s1_addr = 32'h300;
        @(negedge clk);
        chk("l1_cont_first", {smem_rd, sowner}, 2'b10);
        @(negedge clk);
        chk("l1_cont_ack0", {s0_ack, s1_ack}, 2'b10);
        s0_req = 0;
        @(negedge clk);
        chk("l1_cont_gap", {sbusy, s0_ack, s1_ack}, 3'b000);
        @(negedge clk);
        chk("l1_cont_second", {smem_rd, sowner}, 2'b11);
        @(negedge clk);
        chk("l1_cont_ack1", {s0_ack, s1_ack, |s1_rdata}, 3'b010);
        s1_req = 0;

        // random two-master traffic
        @(negedge clk);
        fork
            master(0, 20, 1'b0);
            master(1, 20, 1'b0);
        join

        // both masters requesting continuously
        base = grant_log.size();
        fork
            master(0, 3, 1'b1);
            master(1, 3, 1'b1);
        join
        alt = 1'b1;
        if (grant_log.size() >= base + 6) begin
            for (int i = 1; i < 6; i++)
                if (grant_log[base + i] == grant_log[base + i - 1]) alt = 1'b0;
        end else begin
            alt = 1'b0;
        end
        chk("fair_alternate", {31'(grant_log.size() - base), alt}, {31'd6, 1'b1});

        // reset while a read sits in WAIT
        @(negedge clk);
        req[0] = 1; we[0] = 0; addr[0] = 32'h114; size[0] = 2'd1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!mem_rd && t < 20);
        chk("mid_issue_seen", mem_rd, 1'b1);
        @(negedge clk);
        chk("mid_in_wait", {busy, mem_rd, mem_we, m0_ack}, 4'b1000);
        rst = 1'b0;
        req[0] = 0;
        #1 chk_main_zero("reset_mid_wait");
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        snap = ack_seen;
        repeat (6) @(negedge clk);
        chk("no_ack_after_reset", 64'(ack_seen - snap), 64'h0);

        // contention right after reset
        base = grant_log.size();
        fork
            master(0, 1, 1'b1);
            master(1, 1, 1'b1);
        join
        @(negedge clk);
        @(negedge clk);
        if (grant_log.size() >= base + 2)
            chk("post_reset_order", {grant_log[base], grant_log[base + 1]}, 2'b01);
        else
            chk("post_reset_count", 64'(grant_log.size() - base), 64'd2);

        repeat (4) @(negedge clk);
        chk("queues_drained", 64'(ackq0.size() + ackq1.size() + mq.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
